// File: rtl/fabric_launch_ctrl.sv
// Streams a segmented instruction image into the fabric rows, fires call, waits for every row's ret.
// Optional return watchdog under LAUNCH_TIMEOUT_EN; without it WAIT_RET waits forever.
module fabric_launch_ctrl #(
    parameter int ROWS             = 2,
    parameter int COLS             = 2,
    parameter int INSTR_DATA_WIDTH = 27,
    parameter int INSTR_ADDR_WIDTH = 6,
    parameter int INSTR_HOPS_WIDTH = 4,
    parameter int IMEM_ADDR_WIDTH  = 12,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [IMEM_ADDR_WIDTH-1:0]           start_addr,
    output logic                                 imem_en,
    output logic [IMEM_ADDR_WIDTH-1:0]           imem_addr,
    input  logic [INSTR_DATA_WIDTH-1:0]          imem_rdata,
    output logic [ROWS*INSTR_DATA_WIDTH-1:0]     instr_data_out,
    output logic [ROWS*INSTR_ADDR_WIDTH-1:0]     instr_addr_out,
    output logic [ROWS*INSTR_HOPS_WIDTH-1:0]     instr_hops_out,
    output logic [ROWS-1:0]                      instr_en_out,
    output logic [ROWS-1:0]                      call,
    input  logic [ROWS-1:0]                      ret,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error
);
    localparam int DW = INSTR_DATA_WIDTH;
    localparam int AW = INSTR_ADDR_WIDTH;
    localparam int HW = INSTR_HOPS_WIDTH;
    localparam int MW = IMEM_ADDR_WIDTH;
    localparam int CW = AW + 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = $clog2(2 * COLS) + 1;

    typedef enum logic [2:0] {
        IDLE, HDR_REQ, HDR_WAIT, LOAD, CALL, SETTLE, WAIT_RET, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   ptr_q, ptr_d;
    logic [RW-1:0]   row_q, row_d;
    logic [HW-1:0]   col_q, col_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   slot_q, slot_d;
    logic            vld_q, vld_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            err_q, err_d;

    logic [7:0] hdr_cnt, hdr_col, hdr_row;
    assign hdr_cnt = imem_rdata[7:0];
    assign hdr_col = imem_rdata[15:8];
    assign hdr_row = imem_rdata[23:16];

`ifdef LAUNCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        row_d    = row_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        slot_d   = slot_q;
        vld_d    = 1'b0;
        settle_d = settle_q;
        err_d    = err_q;
        imem_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = start_addr;
                    err_d   = 1'b0;
                    state_d = HDR_REQ;
                end
            end
            HDR_REQ: begin
                imem_en = 1'b1;
                ptr_d   = ptr_q + MW'(1);
                state_d = HDR_WAIT;
            end
            HDR_WAIT: begin
                if (hdr_cnt == 8'd0) begin
                    state_d = CALL;
                end else if (int'(hdr_row) >= ROWS || int'(hdr_col) >= COLS ||
                             int'(hdr_cnt) > (1 << AW)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    row_d   = RW'(hdr_row);
                    col_d   = HW'(hdr_col);
                    cnt_d   = CW'(hdr_cnt);
                    rd_d    = '0;
                    slot_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Reads run one cycle ahead of the strobes they feed.
                if (rd_q != cnt_q) begin
                    imem_en = 1'b1;
                    ptr_d   = ptr_q + MW'(1);
                    rd_d    = rd_q + CW'(1);
                    vld_d   = 1'b1;
                end
                if (vld_q) begin
                    slot_d = slot_q + AW'(1);
                    if ({1'b0, slot_q} == cnt_q - CW'(1))
                        state_d = HDR_REQ;
                end
            end
            CALL: begin
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                settle_d = settle_q + SW'(1);
                if (settle_q == SW'(2 * COLS - 1))
                    state_d = WAIT_RET;
            end
            WAIT_RET: begin
                if (&ret)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef LAUNCH_TIMEOUT_EN
        tmo_d = '0;
        if (state_q == SETTLE || state_q == WAIT_RET) begin
            tmo_d = tmo_q + TW'(1);
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1) && !(state_q == WAIT_RET && (&ret))) begin
                err_d   = 1'b1;
                state_d = DONE;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            slot_q   <= '0;
            vld_q    <= 1'b0;
            settle_q <= '0;
            err_q    <= 1'b0;
`ifdef LAUNCH_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            row_q    <= row_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            slot_q   <= slot_d;
            vld_q    <= vld_d;
            settle_q <= settle_d;
            err_q    <= err_d;
`ifdef LAUNCH_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Instruction data passes straight from the read port; only the selected row sees it.
    always_comb begin
        instr_data_out = '0;
        instr_addr_out = '0;
        instr_hops_out = '0;
        instr_en_out   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (vld_q && row_q == RW'(r)) begin
                instr_en_out[r]             = 1'b1;
                instr_data_out[r*DW +: DW]  = imem_rdata;
                instr_addr_out[r*AW +: AW]  = slot_q;
                instr_hops_out[r*HW +: HW]  = col_q;
            end
        end
    end

    assign imem_addr = imem_en ? ptr_q : '0;
    assign call      = {ROWS{state_q == CALL}};
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign error     = err_q;

endmodule

// File: tb/tb_fabric_launch_ctrl.sv
// Directed bench for fabric_launch_ctrl: image memory model plus a strobe scoreboard.
// The watchdog step runs only when LAUNCH_TIMEOUT_EN is defined.
module tb_fabric_launch_ctrl;
    localparam int ROWS = 2, COLS = 2, DW = 27, AW = 6, HW = 4, MW = 12, TMO = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [MW-1:0]        start_addr = '0;
    logic                 imem_en;
    logic [MW-1:0]        imem_addr;
    logic [DW-1:0]        imem_rdata;
    logic [ROWS*DW-1:0]   instr_data_out;
    logic [ROWS*AW-1:0]   instr_addr_out;
    logic [ROWS*HW-1:0]   instr_hops_out;
    logic [ROWS-1:0]      instr_en_out;
    logic [ROWS-1:0]      call;
    logic [ROWS-1:0]      ret = '0;
    logic                 busy, done, error;

    fabric_launch_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .INSTR_DATA_WIDTH(DW), .INSTR_ADDR_WIDTH(AW),
        .INSTR_HOPS_WIDTH(HW), .IMEM_ADDR_WIDTH(MW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_data_out(instr_data_out), .instr_addr_out(instr_addr_out),
        .instr_hops_out(instr_hops_out), .instr_en_out(instr_en_out),
        .call(call), .ret(ret), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { int row; logic [DW-1:0] data; int slot; int col; } exp_t;

    logic [DW-1:0] mem [0:4095];
    exp_t sb[$];
    exp_t mon_e;
    int   stb_log[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, call_cnt = 0, done_cnt = 0, call_cyc = 0;
    int   wp = 0;
    bit   mon_on = 1'b0;

    // Unread cycles return noise so idle ports must really be gated.
    always @(posedge clk)
        imem_rdata <= imem_en ? mem[imem_addr] : DW'($urandom);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            for (int r = 0; r < ROWS; r++) begin
                if (instr_en_out[r] === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("stb_unexpected", 64'(instr_en_out), 64'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("stb_row", 64'(r), 64'(mon_e.row));
                        chk("stb_data", 64'(instr_data_out[r*DW +: DW]), 64'(mon_e.data));
                        chk("stb_slot", 64'(instr_addr_out[r*AW +: AW]), 64'(mon_e.slot));
                        chk("stb_hops", 64'(instr_hops_out[r*HW +: HW]), 64'(mon_e.col));
                        stb_log.push_back(cyc);
                    end
                end else begin
                    chk("idle_port", 64'({instr_en_out[r], instr_data_out[r*DW +: DW],
                                          instr_addr_out[r*AW +: AW], instr_hops_out[r*HW +: HW]}), 64'd0);
                end
            end
            if (call !== '0) begin
                call_cnt++;
                call_cyc = cyc;
                chk("call_all_rows", 64'(call), 64'({ROWS{1'b1}}));
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_hdr(input int row, input int col, input int cnt);
        logic [7:0] r8, c8, n8;
        r8 = 8'(row); c8 = 8'(col); n8 = 8'(cnt);
        mem[wp] = DW'({r8, c8, n8});
        wp = (wp + 1) % 4096;
    endtask

    task automatic put_word(input int row, input int col, input int slot, input logic [DW-1:0] w);
        exp_t e;
        mem[wp] = w;
        e.row = row; e.data = w; e.slot = slot; e.col = col;
        sb.push_back(e);
        wp = (wp + 1) % 4096;
    endtask

    task automatic image1();
        wp = 0;
        put_hdr(0, 1, 3);
        put_word(0, 1, 0, 27'h0AAAAAA);
        put_word(0, 1, 1, 27'h5555555);
        put_word(0, 1, 2, 27'h7000001);
        put_hdr(0, 0, 0);
    endtask

    task automatic launch(input int addr);
        start_addr = MW'(addr);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic bit cond(input int which);
        if (which == 0) return |call;
        if (which == 1) return done;
        return |instr_en_out;
    endfunction

    task automatic wait_for(input int which, input int limit, input string tag);
        int n = 0;
        while (n < limit && !cond(which)) begin
            tick();
            n++;
        end
        chk(tag, 64'(cond(which)), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({busy, done, error, imem_en, call}), 64'd0);
        chk({tag, "_iaddr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_instr"}, 64'({instr_en_out, instr_addr_out, instr_hops_out}), 64'd0);
        chk({tag, "_data"}, 64'(instr_data_out), 64'd0);
    endtask

    initial begin
        int c0, d0, n, ct;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        rst_n = 1'b1;
        mon_on = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);

        // Single segment, ret raised late.
        image1();
        stb_log.delete();
        launch(0);
        wait_for(0, 100, "t1_call");
        chk("t1_nstb", 64'(stb_log.size()), 64'd3);
        chk("t1_gap01", 64'(stb_log[1] - stb_log[0]), 64'd1);
        chk("t1_gap12", 64'(stb_log[2] - stb_log[1]), 64'd1);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        chk("t1_call_1cyc", 64'(call), 64'd0);
        repeat (8) tick();
        chk("t1_waiting", 64'({busy, done}), 64'b10);
        ret = '1;
        tick();
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_err", 64'(error), 64'd0);
        tick();
        chk("t1_done_1cyc", 64'({busy, done}), 64'd0);
        ret = '0;

        // Two segments on different rows, ret held high, start pulsed while busy.
        wp = 16;
        put_hdr(0, 0, 2);
        put_word(0, 0, 0, 27'h0123456);
        put_word(0, 0, 1, 27'h6543210);
        put_hdr(1, 1, 1);
        put_word(1, 1, 0, 27'h3C3C3C3);
        put_hdr(0, 0, 0);
        ret = '1;
        c0 = call_cnt;
        start_addr = 12'd16;
        start = 1'b1;
        chk("t2_busy_pre", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            chk("t2_busy_run", 64'(busy), 64'd1);
            start_addr = '0;
            start = (n == 5);
            tick();
            n++;
        end
        start = 1'b0;
        chk("t2_done_seen", 64'(done), 64'd1);
        chk("t2_busy_done", 64'(busy), 64'd1);
        chk("t2_call_to_done", 64'(cyc - call_cyc), 64'(2 * COLS + 2));
        chk("t2_one_call", 64'(call_cnt - c0), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_idle", 64'(busy), 64'd0);
        repeat (2) tick();
        chk("t2_no_relaunch", 64'(busy), 64'd0);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);
        ret = '0;

        // Bad headers: row out of range, column out of range, oversized count.
        for (int i = 0; i < 3; i++) begin
            wp = 32 + 2 * i;
            if (i == 0) put_hdr(ROWS, 0, 1);
            else if (i == 1) put_hdr(0, COLS, 1);
            else put_hdr(0, 0, 65);
            mem[wp] = 27'h1111111;
            c0 = call_cnt;
            chk("t3_err_held", 64'(error), 64'((i == 0) ? 0 : 1));
            launch(32 + 2 * i);
            chk("t3_err_clr", 64'(error), 64'd0);
            wait_for(1, 20, "t3_done");
            chk("t3_err", 64'(error), 64'd1);
            chk("t3_no_call", 64'(call_cnt - c0), 64'd0);
            tick();
        end
        image1();
        ret = '1;
        chk("t3_err_before", 64'(error), 64'd1);
        launch(0);
        chk("t3_err_cleared", 64'(error), 64'd0);
        wait_for(1, 100, "t3_good_done");
        chk("t3_good_err", 64'(error), 64'd0);
        tick();
        ret = '0;

        // Reset pulse in the middle of LOAD.
        image1();
        launch(0);
        wait_for(2, 20, "t4_stb");
        rst_n = 1'b0;
        tick();
        chk_all_zero("t4_rst");
        sb.delete();
        rst_n = 1'b1;
        c0 = call_cnt;
        d0 = done_cnt;
        ret = '1;
        repeat (20) tick();
        chk("t4_no_call", 64'(call_cnt - c0), 64'd0);
        chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t4_idle", 64'(busy), 64'd0);

        // Image straddling the top of the address space.
        wp = 4094;
        put_hdr(1, 0, 2);
        put_word(1, 0, 0, 27'h2468ACE);
        put_word(1, 0, 1, 27'h1357BDF);
        put_hdr(0, 0, 0);
        launch(4094);
        wait_for(1, 100, "t5_done");
        chk("t5_err", 64'(error), 64'd0);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        ret = '0;

`ifdef LAUNCH_TIMEOUT_EN
        image1();
        launch(0);
        wait_for(0, 100, "t6_call");
        ct = cyc;
        wait_for(1, 40, "t6_done");
        chk("t6_latency", 64'(cyc - ct), 64'(TMO + 1));
        chk("t6_err", 64'(error), 64'd1);
        tick();
`else
        ct = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fabric_launch_ctrl.md
FABRIC_LAUNCH_CTRL -- requirements
Module: fabric_launch_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 2, fabric row count.
REQ-002 SHALL have parameter COLS, default 2, fabric column count; cells per row.
REQ-003 SHALL have parameters INSTR_DATA_WIDTH (27), INSTR_ADDR_WIDTH (6) and INSTR_HOPS_WIDTH (4), matching the fabric instruction ports.
REQ-004 SHALL have parameter IMEM_ADDR_WIDTH, default 12, image memory address width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 4096, return watchdog limit.
REQ-006 SHALL have ports:
- clk  in  1  clock; one clock only, all logic on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  launch request pulse; honoured only in IDLE.
- start_addr  in  IMEM_ADDR_WIDTH  first image word address.
- imem_en  out  1  image read strobe.
- imem_addr  out  IMEM_ADDR_WIDTH  image read address.
- imem_rdata  in  INSTR_DATA_WIDTH  read data, valid exactly 1 cycle after imem_en.
- instr_data_out  out  ROWS x INSTR_DATA_WIDTH  instruction word per row.
- instr_addr_out  out  ROWS x INSTR_ADDR_WIDTH  slot index within the cell.
- instr_hops_out  out  ROWS x INSTR_HOPS_WIDTH  target column.
- instr_en_out  out  ROWS  instruction write strobe per row.
- call  out  ROWS  launch pulse per row.
- ret  in  ROWS  per-row completion level.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky error flag.

Function
REQ-007 SHALL use the header word layout count=[7:0], col=[15:8], row=[23:16]; count instruction words follow each header; a header with count==0 terminates the image.
REQ-008 SHALL implement states IDLE, HDR_REQ, HDR_WAIT, LOAD, CALL, SETTLE, WAIT_RET and DONE.
REQ-009 IDLE: when start=1, SHALL latch start_addr as the pointer, clear error and enter HDR_REQ.
REQ-010 HDR_REQ: SHALL assert imem_en with imem_addr=pointer, increment the pointer and enter HDR_WAIT.
REQ-011 HDR_WAIT: SHALL decode imem_rdata as follows:
- count==0: enter CALL.
- row>=ROWS, col>=COLS or count>2^INSTR_ADDR_WIDTH: set error and enter DONE.
- otherwise: latch row/col/count, clear the slot index and enter LOAD.
REQ-012 LOAD: SHALL issue one body read per cycle at consecutive addresses, pipelined; each word SHALL appear on the instruction ports 1 cycle after its read, with:
- instr_en_out[row]=1;
- instr_hops_out[row]=col;
- instr_addr_out[row]=slot index, 0..count-1.
REQ-013 Non-selected rows SHALL see en/data/addr/hops all zero; an idle instruction port SHALL drive zeros.
REQ-014 Exactly count strobes SHALL be issued per segment; the cycle after the last strobe SHALL enter HDR_REQ at the next address.
REQ-015 CALL: SHALL assert all call bits for exactly one cycle, then enter SETTLE.
REQ-016 SETTLE: SHALL wait exactly 2*COLS cycles, ignoring ret, then enter WAIT_RET.
REQ-017 WAIT_RET: SHALL enter DONE in the cycle after &ret==1 is sampled.
REQ-018 DONE: SHALL pulse done for one cycle, then return to IDLE.
REQ-019 start SHALL be ignored whenever busy=1.
REQ-020 A start and a DONE-to-IDLE transition in the same cycle SHALL NOT launch; start is sampled only while in IDLE.
REQ-021 imem_addr SHALL wrap modulo 2^IMEM_ADDR_WIDTH with no error.

Reset
REQ-022 While rst_n=0 at a clock edge: state=IDLE, pointer and counters=0, and every output (imem_en, imem_addr, instr_*, call, busy, done, error) =0.
REQ-023 Reset mid-operation SHALL abort immediately; there SHALL be no call pulse or done pulse after reset is released until a new start.

Configuration
REQ-024 With macro LAUNCH_TIMEOUT_EN defined, a counter SHALL run during SETTLE+WAIT_RET; reaching TIMEOUT_CYCLES without &ret SHALL set error and enter DONE.
REQ-025 With LAUNCH_TIMEOUT_EN undefined, no counter SHALL exist and WAIT_RET SHALL wait indefinitely; TIMEOUT_CYCLES is then unused.

Verification
REQ-026 Image at 0x000: hdr(row0,col1,count3), words A,B,C, hdr(count0). Start -> row0 strobes with addr 0,1,2, hops 1, data A,B,C on consecutive cycles; call=all-ones for 1 cycle; done pulse 1 cycle after &ret rises.
REQ-027 Two segments, row0/col0 count2 then row1/col1 count1 -> strobes only on the addressed row, other rows zero; busy high from the cycle after start until DONE.
REQ-028 Header row=ROWS -> error=1, done pulse, no instr_en_out and no call; next start clears error.
REQ-029 ret held 1 throughout -> done no earlier than 2*COLS cycles after the call pulse; start asserted while busy -> no effect.
REQ-030 rst_n=0 during LOAD for 1 cycle -> all outputs 0 next cycle; no call afterwards.
REQ-031 LAUNCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, ret held 0 -> error=1 and done pulse 16 cycles after SETTLE entry.
